imem_loadable: RTL

Parametrised, loadable instruction memory for the single-cycle and pipelined MIPS cores. It provides a registered fetch port with stall and flush control, and a load port with a valid/ready handshake for writing program words at run time. After reset, an init state machine clears every word to the NOP encoding before the memory accepts fetches or loads. It sits between the PC register and the decode stage.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_loadable_if.sv | 29 ++
 rtl/imem_ram.sv | 52 +++++
 rtl/imem_loadable.sv | 119 +++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } imem_state_t;

  // MIPS "sll $0,$0,0", the canonical NOP
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Bits needed to count/index DEPTH words; never less than one bit
  function automatic int clear_cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_loadable_if.sv
// Fetch port and load port of the instruction memory, bundled for the core.
interface imem_loadable_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              fetch_en;
  logic [ADDR_W-1:0] address;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ready;

  modport master (
    output fetch_en, address, stall, flush, ld_valid, ld_addr, ld_data,
    input  instruction, instr_valid, ld_ready, ready
  );

  modport slave (
    input  fetch_en, address, stall, flush, ld_valid, ld_addr, ld_data,
    output instruction, instr_valid, ld_ready, ready
  );

endinterface

// File: rtl/imem_ram.sv
// Word storage: one write port, one registered read port that returns the
// word being written when both ports hit the same address in one cycle.
module imem_ram import imem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] OOR_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = clear_cnt_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              w_in_range;
  logic              r_in_range;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;

  assign w_in_range = ({1'b0, waddr} < DEPTH_L);
  assign r_in_range = ({1'b0, raddr} < DEPTH_L);
  assign widx       = waddr[IDX_W-1:0];
  assign ridx       = raddr[IDX_W-1:0];

  // Writes beyond the implemented words are dropped
  always_ff @(posedge clk) begin
    if (we && w_in_range) begin
      mem[widx] <= wdata;
    end
  end

  // Registered read; bypass the array when the same word is being written
  always_ff @(posedge clk) begin
    if (re) begin
      if (!r_in_range) begin
        rdata <= OOR_WORD;
      end else if (we && w_in_range && (waddr == raddr)) begin
        rdata <= wdata;
      end else begin
        rdata <= mem[ridx];
      end
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: clears itself to NOP after reset, then serves
// registered fetches (with stall/flush) and run-time program loads.
module imem_loadable import imem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_loadable_if.slave  bus
);

  localparam int CNT_W = clear_cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  imem_state_t       state;
  imem_state_t       state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              ready_q;
  logic              valid_q;
  logic              nop_q;
  logic              ld_fire;
  logic              re;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign ld_fire = bus.ld_valid & ready_q;
  assign re      = ready_q & bus.fetch_en & ~bus.stall & ~bus.flush;

  // State and clear counter; reset restarts the clear sweep from word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_CLEAR ? CLEAR : RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and write mux: clear sweep owns the write port during CLEAR
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    we         = ld_fire;
    waddr      = bus.ld_addr;
    wdata      = bus.ld_data;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = ADDR_W'(cnt);
        wdata = NOP_WORD;
        if (cnt == CNT_LAST) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // Output control: flush beats stall beats fetch; nop_q masks the RAM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      nop_q   <= 1'b1;
    end else begin
      ready_q <= (state == RUN);
      if (!ready_q) begin
        valid_q <= 1'b0;
        nop_q   <= 1'b1;
      end else if (bus.flush) begin
        valid_q <= 1'b0;
        nop_q   <= 1'b1;
      end else if (bus.stall) begin
        valid_q <= valid_q;
        nop_q   <= nop_q;
      end else if (bus.fetch_en) begin
        valid_q <= 1'b1;
        nop_q   <= 1'b0;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  imem_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .OOR_WORD (NOP_WORD)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (bus.address),
    .rdata (ram_rdata)
  );

  assign bus.instruction = nop_q ? NOP_WORD : ram_rdata;
  assign bus.instr_valid = valid_q;
  assign bus.ready       = ready_q;
  assign bus.ld_ready    = ready_q;

endmodule
